// File: rtl/bn_relu_tm_if.sv
// Stream and coefficient-load signals for bn_relu_tm.
// master = upstream/downstream environment, slave = the BN/ReLU stage.
interface bn_relu_tm_if #(
  parameter int NO_CH = 64,
  parameter int PAR   = 8,
  parameter int BW    = 12,
  parameter int CW    = 16
);
  localparam int NB = NO_CH / PAR;
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [PAR*CW-1:0] cfg_a;
  logic [PAR*CW-1:0] cfg_b;
  logic              beat_clr;
  logic              vld_in;
  logic              rdy_in;
  logic [PAR*BW-1:0] data_in;
  logic              vld_out;
  logic              rdy_out;
  logic [PAR*BW-1:0] data_out;
  logic              last_out;

  modport master (
    output cfg_we, cfg_addr, cfg_a, cfg_b, beat_clr, vld_in, data_in, rdy_out,
    input  rdy_in, vld_out, data_out, last_out
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_a, cfg_b, beat_clr, vld_in, data_in, rdy_out,
    output rdy_in, vld_out, data_out, last_out
  );
endinterface

// File: rtl/bn_relu_tm.sv
// Time-multiplexed batch-norm (a*x + b<<B_SHIFT, rounded, >>> R_SHIFT) with ReLU/signed saturation.
// Latency: 4 cycles accept-to-output, 1 beat/cycle.
// Backpressure: whole pipeline freezes while the output is held (vld_out && !rdy_out); rdy_in follows.
module bn_relu_tm #(
  parameter int NO_CH   = 64,
  parameter int PAR     = 8,
  parameter int BW      = 12,
  parameter int CW      = 16,
  parameter int R_SHIFT = 6,
  parameter int B_SHIFT = 4,
  parameter int RELU    = 1,
  parameter int ROUND   = 1
) (
  input  logic        clk,
  input  logic        rst,
  bn_relu_tm_if.slave bus
);
  localparam int NB = NO_CH / PAR;
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = CW + BW;
  localparam int SW = CW + BW + B_SHIFT + 2;

  localparam int RND_I  = (ROUND != 0 && R_SHIFT > 0) ? (1 << (R_SHIFT - 1)) : 0;
  localparam int MAXV_I = (1 << (BW - 1)) - 1;
  localparam int MINV_I = (RELU != 0) ? 0 : -(1 << (BW - 1));

  localparam logic signed [SW-1:0] RND   = SW'(RND_I);
  localparam logic signed [SW-1:0] MAXV  = SW'(MAXV_I);
  localparam logic signed [SW-1:0] MINV  = SW'(MINV_I);
  localparam logic signed [BW-1:0] MAX_O = BW'(MAXV_I);
  localparam logic signed [BW-1:0] MIN_O = BW'(MINV_I);

  if (NO_CH % PAR != 0) begin : g_bad_par
    $error("NO_CH must be a multiple of PAR");
  end

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

  logic [PAR*2*CW-1:0] tbl [NB];
  logic [AW-1:0]       bcnt;
  logic [AW-1:0]       idx;
  logic [PAR*CW-1:0]   a_row;
  logic [PAR*CW-1:0]   b_row;
  logic                en;
  logic                acc;

  tag_t t1, t2, t3, t4;

  logic signed [PW-1:0] prod   [PAR];
  logic signed [CW-1:0] b1     [PAR];
  logic signed [SW-1:0] sum    [PAR];
  logic signed [SW-1:0] sh     [PAR];
  logic signed [PW-1:0] prod_c [PAR];
  logic signed [CW-1:0] b_c    [PAR];
  logic signed [SW-1:0] sum_c  [PAR];
  logic signed [SW-1:0] sh_c   [PAR];
  logic [PAR*BW-1:0]    out_c;
  logic [PAR*BW-1:0]    dout;

  assign en  = !t4.vld || bus.rdy_out;
  assign acc = bus.vld_in && en;

  // beat_clr steers the current beat to entry 0 even while bcnt still holds its old value
  assign idx   = bus.beat_clr ? '0 : bcnt;
  assign a_row = tbl[idx][PAR*CW-1:0];
  assign b_row = tbl[idx][PAR*2*CW-1:PAR*CW];

  // Table is deliberately outside reset so coefficients survive a stream restart.
  // The read above is combinational, so a same-cycle write is only seen by later beats.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      tbl[bus.cfg_addr] <= {bus.cfg_b, bus.cfg_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
    end else if (acc) begin
      bcnt <= (idx == AW'(NB - 1)) ? '0 : idx + AW'(1);
    end else if (bus.beat_clr) begin
      bcnt <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < PAR; i++) begin
      prod_c[i] = PW'($signed(a_row[i*CW +: CW])) * PW'($signed(bus.data_in[i*BW +: BW]));
      b_c[i]    = $signed(b_row[i*CW +: CW]);
      sum_c[i]  = SW'(prod[i]) + (SW'(b1[i]) <<< B_SHIFT) + RND;
      sh_c[i]   = sum[i] >>> R_SHIFT;
    end
  end

  always_comb begin
    out_c = '0;
    for (int i = 0; i < PAR; i++) begin
      if (sh[i] > MAXV) begin
        out_c[i*BW +: BW] = MAX_O;
      end else if (sh[i] < MINV) begin
        out_c[i*BW +: BW] = MIN_O;
      end else begin
        out_c[i*BW +: BW] = sh[i][BW-1:0];
      end
    end
  end

  // Datapath registers move with en regardless of valid; bubbles carry don't-care data.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < PAR; i++) begin
        prod[i] <= prod_c[i];
        b1[i]   <= b_c[i];
        sum[i]  <= sum_c[i];
        sh[i]   <= sh_c[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t1   <= '0;
      t2   <= '0;
      t3   <= '0;
      t4   <= '0;
      dout <= '0;
    end else if (en) begin
      t1.vld  <= acc;
      t1.last <= acc && (idx == AW'(NB - 1));
      t2      <= t1;
      t3      <= t2;
      t4      <= t3;
      dout    <= out_c;
    end
  end

  assign bus.rdy_in   = en;
  assign bus.vld_out  = t4.vld;
  assign bus.last_out = t4.last;
  assign bus.data_out = dout;
endmodule

// File: tb/tb_bn_relu_tm.sv
// Directed bench: one DUT with ReLU+rounding, one with signed saturation+truncation, same stimulus.
module tb_bn_relu_tm;
  localparam int NO_CH = 64;
  localparam int PAR   = 8;
  localparam int BW    = 12;
  localparam int CW    = 16;
  localparam int NB    = NO_CH / PAR;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [PAR*CW-1:0] cfg_a;
  logic [PAR*CW-1:0] cfg_b;
  logic              beat_clr;
  logic              vld_in;
  logic              rdy_out;
  logic [PAR*BW-1:0] data_in;

  bn_relu_tm_if #(.NO_CH(NO_CH), .PAR(PAR), .BW(BW), .CW(CW)) ifa ();
  bn_relu_tm_if #(.NO_CH(NO_CH), .PAR(PAR), .BW(BW), .CW(CW)) ifb ();

  assign ifa.cfg_we   = cfg_we;
  assign ifa.cfg_addr = cfg_addr;
  assign ifa.cfg_a    = cfg_a;
  assign ifa.cfg_b    = cfg_b;
  assign ifa.beat_clr = beat_clr;
  assign ifa.vld_in   = vld_in;
  assign ifa.data_in  = data_in;
  assign ifa.rdy_out  = rdy_out;
  assign ifb.cfg_we   = cfg_we;
  assign ifb.cfg_addr = cfg_addr;
  assign ifb.cfg_a    = cfg_a;
  assign ifb.cfg_b    = cfg_b;
  assign ifb.beat_clr = beat_clr;
  assign ifb.vld_in   = vld_in;
  assign ifb.data_in  = data_in;
  assign ifb.rdy_out  = rdy_out;

  bn_relu_tm #(.NO_CH(NO_CH), .PAR(PAR), .BW(BW), .CW(CW), .R_SHIFT(6), .B_SHIFT(4),
               .RELU(1), .ROUND(1)) u_relu (.clk(clk), .rst(rst), .bus(ifa));
  bn_relu_tm #(.NO_CH(NO_CH), .PAR(PAR), .BW(BW), .CW(CW), .R_SHIFT(6), .B_SHIFT(4),
               .RELU(0), .ROUND(0)) u_sat (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int failures = 0;
  int xv [PAR];
  int e0 [PAR];
  int e1 [PAR];
  int q0 [$];
  int q1 [$];
  int ql [$];
  int seq_exp [21] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 3, 4, 5, 6, 7, 8, 1, 2, 3, 1, 2};
  int bp_exp  [10] = '{1, 4, 9, 16, 25, 36, 49, 64, 9, 20};

  function automatic logic signed [31:0] lane(input logic [PAR*BW-1:0] v, input int i);
    logic signed [BW-1:0] t;
    t = v[i*BW +: BW];
    return 32'(t);
  endfunction

  // One record per completed output transfer (the posedge following this negedge).
  always @(negedge clk) begin
    if (!rst && ifa.vld_out && rdy_out) begin
      q0.push_back(lane(ifa.data_out, 0));
      q1.push_back(lane(ifb.data_out, 0));
      ql.push_back(int'(ifa.last_out));
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int a, input int b);
    cfg_we   = 1'b1;
    cfg_addr = AW'(k);
    for (int i = 0; i < PAR; i++) begin
      cfg_a[i*CW +: CW] = CW'(a);
      cfg_b[i*CW +: CW] = CW'(b);
    end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_all(input int x);
    for (int i = 0; i < PAR; i++) data_in[i*BW +: BW] = BW'(x);
  endtask

  task automatic clear_q();
    q0.delete();
    q1.delete();
    ql.delete();
  endtask

  // Single vector through entry 0; checks latency and every lane of both DUTs.
  task automatic run_vec(input string tag, input int a, input int b);
    int n;
    load(0, a, b);
    for (int i = 0; i < PAR; i++) data_in[i*BW +: BW] = BW'(xv[i]);
    vld_in   = 1'b1;
    beat_clr = 1'b1;
    tick();
    vld_in   = 1'b0;
    beat_clr = 1'b0;
    n = 1;
    while (!ifa.vld_out && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_vld_sat"}, 32'(ifb.vld_out), 1);
    for (int i = 0; i < PAR; i++) begin
      check($sformatf("%s_relu_l%0d", tag, i), lane(ifa.data_out, i), e0[i]);
      check($sformatf("%s_sat_l%0d", tag, i), lane(ifb.data_out, i), e1[i]);
    end
    tick();
  endtask

  // Offers one beat and returns just after the edge that accepted it.
  task automatic send(input int x, input bit clr);
    bit ok;
    ok = 1'b0;
    set_all(x);
    vld_in   = 1'b1;
    beat_clr = clr;
    for (int g = 0; g < 64 && !ok; g++) begin
      @(negedge clk);
      ok = ifa.rdy_in;
    end
    if (!ok) check("send_timeout", 0, 1);
    tick();
    vld_in   = 1'b0;
    beat_clr = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    for (int g = 0; g < 200 && q0.size() < n; g++) tick();
    repeat (6) tick();
    check({tag, "_count"}, q0.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_idx;
    int hold_exp;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_a = '0; cfg_b = '0;
    beat_clr = 1'b0; vld_in = 1'b0; rdy_out = 1'b1; data_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_vld_relu", 32'(ifa.vld_out), 0);
    check("rst_vld_sat", 32'(ifb.vld_out), 0);
    check("rst_last", 32'(ifa.last_out), 0);
    check("rst_rdy_in", 32'(ifa.rdy_in), 1);
    check("rst_data_l0", lane(ifa.data_out, 0), 0);
    check("rst_data_l7", lane(ifb.data_out, PAR-1), 0);

    xv = '{100, -100, 0, 1, 5, 2047, -2048, 31};
    e0 = '{100, 0, 0, 1, 5, 2047, 0, 31};
    e1 = '{100, -100, 0, 1, 5, 2047, -2048, 31};
    run_vec("unity", 64, 0);

    xv = '{10, -10, 0, 1, 2, 3, 100, -1};
    e0 = '{11, 0, 1, 2, 3, 4, 101, 0};
    e1 = '{11, -9, 1, 2, 3, 4, 101, 0};
    run_vec("bias", 64, 4);

    xv = '{96, 32, 31, -32, -33, 64, 0, -96};
    e0 = '{2, 1, 0, 0, 0, 1, 0, 0};
    e1 = '{1, 0, 0, -1, -1, 1, 0, -2};
    run_vec("round", 1, 0);

    xv = '{2047, -2048, 1, -1, 2, 0, 200, -200};
    e0 = '{2047, 0, 512, 0, 1024, 0, 2047, 0};
    e1 = '{2047, -2048, 511, -512, 1023, 0, 2047, -2048};
    run_vec("satur", 32767, 0);

    // Entry 0 holds a=32767; rewrite it in the same cycle a beat reads it.
    clear_q();
    cfg_we = 1'b1; cfg_addr = '0;
    for (int i = 0; i < PAR; i++) begin
      cfg_a[i*CW +: CW] = CW'(64);
      cfg_b[i*CW +: CW] = '0;
    end
    set_all(1); vld_in = 1'b1; beat_clr = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    vld_in = 1'b0; beat_clr = 1'b0;
    drain("wr_coll", 2);
    if (q0.size() >= 2) begin
      check("wr_coll_old_relu", q0[0], 512);
      check("wr_coll_old_sat", q1[0], 511);
      check("wr_coll_new_relu", q0[1], 1);
      check("wr_coll_new_sat", q1[1], 1);
    end

    for (int k = 0; k < NB; k++) load(k, 64 * (k + 1), 0);
    beat_clr = 1'b1;
    tick();
    beat_clr = 1'b0;
    clear_q();
    for (int j = 0; j < 17; j++) send(1, j == 16);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b1);
    send(1, 1'b0);
    drain("seq", 21);
    for (int j = 0; j < 21 && j < q0.size(); j++) begin
      check($sformatf("seq_relu_%0d", j), q0[j], seq_exp[j]);
      check($sformatf("seq_sat_%0d", j), q1[j], seq_exp[j]);
      check($sformatf("seq_last_%0d", j), ql[j], (j == 7 || j == 15) ? 1 : 0);
    end

    beat_clr = 1'b1;
    tick();
    beat_clr = 1'b0;
    clear_q();
    fork
      begin
        for (int j = 0; j < 10; j++) send(j + 1, 1'b0);
      end
      begin
        for (int g = 0; g < 100 && q0.size() < 3; g++) tick();
        hold_idx = q0.size();
        hold_exp = (hold_idx + 1) * ((hold_idx % NB) + 1);
        rdy_out = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_rdy_in", 32'(ifa.rdy_in), 0);
          check("bp_vld_hold", 32'(ifa.vld_out), 1);
          check("bp_data_hold", lane(ifa.data_out, 0), hold_exp);
          check("bp_sat_hold", lane(ifb.data_out, 0), hold_exp);
          tick();
        end
        rdy_out = 1'b1;
      end
    join
    drain("bp", 10);
    for (int j = 0; j < 10 && j < q0.size(); j++) begin
      check($sformatf("bp_relu_%0d", j), q0[j], bp_exp[j]);
      check($sformatf("bp_sat_%0d", j), q1[j], bp_exp[j]);
      check($sformatf("bp_last_%0d", j), ql[j], (j == 7) ? 1 : 0);
    end

    clear_q();
    send(5, 1'b0);
    send(6, 1'b0);
    send(7, 1'b0);
    rst = 1'b1;
    tick();
    check("mrst_vld_relu", 32'(ifa.vld_out), 0);
    check("mrst_vld_sat", 32'(ifb.vld_out), 0);
    check("mrst_last", 32'(ifa.last_out), 0);
    check("mrst_rdy_in", 32'(ifa.rdy_in), 1);
    check("mrst_data_l0", lane(ifa.data_out, 0), 0);
    check("mrst_data_l7", lane(ifb.data_out, PAR-1), 0);
    rst = 1'b0;
    repeat (6) tick();
    check("mrst_no_output", q0.size(), 0);
    send(3, 1'b0);
    drain("post_rst", 1);
    if (q0.size() >= 1) begin
      check("post_rst_relu", q0[0], 3);
      check("post_rst_sat", q1[0], 3);
      check("post_rst_last", ql[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
